// File: rtl/visualizer_pkg.sv
// Shared constants and helpers for the stereo VU meter: saturating magnitude
// and the log-scale thermometer encoder.
package visualizer_pkg;

  localparam int SAMPLE_W_DEF     = 16;
  localparam int NUM_LIGHTS_DEF   = 10;
  localparam int DECAY_CYCLES_DEF = 1024;
  localparam int DECAY_SHIFT_DEF  = 3;

  // Helpers work on a fixed wide word; callers sign-extend in and truncate out.
  localparam int MAX_W = 32;

  // |s| for a w-bit sample carried sign-extended in MAX_W bits; the most
  // negative w-bit value clamps to 2^(w-1)-1 so the result fits w-1 bits.
  function automatic logic [MAX_W-1:0] sat_abs(input logic signed [MAX_W-1:0] s,
                                               input int unsigned             w);
    logic [MAX_W-1:0] lim;
    logic [MAX_W-1:0] mag;
    lim = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    mag = s[MAX_W-1] ? $unsigned(-s) : $unsigned(s);
    return (mag > lim) ? lim : mag;
  endfunction

  // Bit k set when env >= 2^(k+ofs); bits at and above n stay 0.
  function automatic logic [MAX_W-1:0] thermo(input logic [MAX_W-1:0] env,
                                              input int unsigned      n,
                                              input int unsigned      ofs);
    logic [MAX_W-1:0] bar;
    bar = '0;
    for (int unsigned k = 0; k < MAX_W; k++) begin
      if (k < n) bar[k] = (env >= (MAX_W'(1) << (k + ofs)));
    end
    return bar;
  endfunction

endpackage

// File: rtl/peak_envelope.sv
// Peak envelope follower: instant attack, stepped exponential decay driven by
// a free-running tick counter.
module peak_envelope
  import visualizer_pkg::*;
#(
  parameter int W            = SAMPLE_W_DEF - 1,
  parameter int DECAY_CYCLES = DECAY_CYCLES_DEF,
  parameter int DECAY_SHIFT  = DECAY_SHIFT_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] level,
  output logic [W-1:0] env
);

  localparam int CW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic          tick;
  logic [W-1:0]  step;
  logic [W-1:0]  env_next;

  assign tick = (cnt == CW'(DECAY_CYCLES - 1));

  // A step of at least 1 guarantees a silent input decays all the way to 0.
  always_comb begin
    step     = env >> DECAY_SHIFT;
    env_next = env;
    if (step == '0) step = W'(1);
    if (level > env)               env_next = level;
    else if (tick && env != '0)    env_next = env - step;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
      env <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      env <= env_next;
    end
  end

endmodule

// File: rtl/audio_visualizer.sv
// Stereo VU meter: |L|,|R| -> mono average -> peak envelope -> log bar graph.
// Four registered stages; a sample at edge N shows on lights after edge N+3.
module audio_visualizer
  import visualizer_pkg::*;
#(
  parameter int SAMPLE_W     = SAMPLE_W_DEF,
  parameter int NUM_LIGHTS   = NUM_LIGHTS_DEF,
  parameter int DECAY_CYCLES = DECAY_CYCLES_DEF,
  parameter int DECAY_SHIFT  = DECAY_SHIFT_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] left,
  input  logic signed [SAMPLE_W-1:0] right,
  output logic [NUM_LIGHTS-1:0]      lights
);

  localparam int MW  = SAMPLE_W - 1;
  localparam int OFS = SAMPLE_W - 1 - NUM_LIGHTS;

  logic [MW-1:0]       mag_l;
  logic [MW-1:0]       mag_r;
  logic [SAMPLE_W-1:0] sum;
  logic [MW-1:0]       mono;
  logic [MW-1:0]       env;

  always_ff @(posedge clock) begin
    if (!reset) begin
      mag_l <= '0;
      mag_r <= '0;
    end else begin
      mag_l <= MW'(sat_abs(MAX_W'(left),  SAMPLE_W));
      mag_r <= MW'(sat_abs(MAX_W'(right), SAMPLE_W));
    end
  end

  // Two (SAMPLE_W-1)-bit magnitudes sum into SAMPLE_W bits without overflow.
  assign sum = {1'b0, mag_l} + {1'b0, mag_r};

  always_ff @(posedge clock) begin
    if (!reset) mono <= '0;
    else        mono <= sum[SAMPLE_W-1:1];
  end

  peak_envelope #(
    .W            (MW),
    .DECAY_CYCLES (DECAY_CYCLES),
    .DECAY_SHIFT  (DECAY_SHIFT)
  ) u_env (
    .clock (clock),
    .reset (reset),
    .level (mono),
    .env   (env)
  );

  always_ff @(posedge clock) begin
    if (!reset) lights <= '0;
    else        lights <= NUM_LIGHTS'(thermo(MAX_W'(env), NUM_LIGHTS, OFS));
  end

endmodule

// File: tb/tb_audio_visualizer.sv
// Bench for audio_visualizer: a default-parameter DUT and a fast-decay DUT
// share one stimulus stream, each checked against an arithmetic model.
module tb_audio_visualizer;

  localparam int SW  = 16;
  localparam int NL  = 10;
  localparam int OFS = SW - 1 - NL;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic signed [SW-1:0] left  = '0;
  logic signed [SW-1:0] right = '0;
  logic [NL-1:0]        lights_a;
  logic [NL-1:0]        lights_b;

  always #5 clock = ~clock;

  audio_visualizer #(.SAMPLE_W(SW), .NUM_LIGHTS(NL), .DECAY_CYCLES(1024), .DECAY_SHIFT(3))
    dut_a (.clock(clock), .reset(reset), .left(left), .right(right), .lights(lights_a));

  audio_visualizer #(.SAMPLE_W(SW), .NUM_LIGHTS(NL), .DECAY_CYCLES(4), .DECAY_SHIFT(1))
    dut_b (.clock(clock), .reset(reset), .left(left), .right(right), .lights(lights_b));

  int total = 0;
  int bad   = 0;

  // Model state per config: mono delay line, envelope, tick phase, shown bar.
  int dc[2] = '{1024, 4};
  int ds[2] = '{3, 1};
  int q1[2], q2[2], env_m[2], ph[2], lit[2];

  function automatic int mag_of(input int s);
    int a;
    a = (s < 0) ? -s : s;
    return (a > 32767) ? 32767 : a;
  endfunction

  function automatic int mono_of(input int l, input int r);
    return (mag_of(l) + mag_of(r)) / 2;
  endfunction

  // LED count = floor(log2(env)) - OFS + 1, clamped to 0..NL.
  function automatic int bar(input int e);
    int p, v, n;
    p = -1;
    v = e;
    while (v > 0) begin
      v = v >> 1;
      p++;
    end
    n = p - OFS + 1;
    if (n < 0)  n = 0;
    if (n > NL) n = NL;
    return (1 << n) - 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    int  m, d;
    logic tk;
    @(posedge clock);
    m = mono_of(int'(left), int'(right));
    for (int c = 0; c < 2; c++) begin
      if (!reset) begin
        q1[c] = 0; q2[c] = 0; env_m[c] = 0; ph[c] = 0; lit[c] = 0;
      end else begin
        lit[c] = bar(env_m[c]);
        tk = (ph[c] == dc[c] - 1);
        if (q2[c] > env_m[c]) env_m[c] = q2[c];
        else if (tk && env_m[c] != 0) begin
          d = env_m[c] >> ds[c];
          if (d < 1) d = 1;
          env_m[c] = env_m[c] - d;
        end
        ph[c] = (ph[c] + 1) % dc[c];
        q2[c] = q1[c];
        q1[c] = m;
      end
    end
    #1;
  endtask

  task automatic check_both(input string tag);
    check({tag, "/a"}, 32'(lights_a), 32'(lit[0]));
    check({tag, "/b"}, 32'(lights_b), 32'(lit[1]));
  endtask

  task automatic set_in(input int l, input int r);
    left  = SW'(l);
    right = SW'(r);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    clk_step();
    check("rst_pulse", 32'(lights_a), 0);
    reset = 1'b1;
  endtask

  initial begin
    int prev_n, cur_n;

    // Reset held low with random inputs
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      left  = SW'($urandom);
      right = SW'($urandom);
      clk_step();
      check("rst_a", 32'(lights_a), 0);
      check("rst_b", 32'(lights_b), 0);
    end

    // Silence
    reset = 1'b1;
    set_in(0, 0);
    for (int i = 0; i < 10; i++) begin
      clk_step();
      check("silence", 32'(lights_a), 0);
      check_both("silence_m");
    end

    // Full scale: latency of exactly three edges after the first sample edge
    set_in(16384, 16384);
    for (int i = 1; i <= 4; i++) begin
      clk_step();
      check("full_lat", 32'(lights_a), (i == 4) ? 32'h3FF : 32'h0);
      check_both("full_m");
    end
    for (int i = 0; i < 4; i++) begin
      clk_step();
      check_both("full_hold");
    end

    // Saturation of the most negative sample
    reset_pulse();
    set_in(-32768, 0);
    repeat (4) clk_step();
    check("sat", 32'(lights_a), 32'h1FF);
    check_both("sat_m");

    // Mono averaging of small levels
    reset_pulse();
    set_in(100, 100);
    repeat (4) clk_step();
    check("avg100", 32'(lights_a), 32'h003);
    check_both("avg_m");

    // Decay on the fast-decay instance, with a re-attack mid-way
    reset_pulse();
    set_in(16384, 16384);
    repeat (8) clk_step();
    check("dec_full", 32'(lights_b), 32'h3FF);
    set_in(0, 0);
    for (int i = 0; i < 14; i++) begin
      clk_step();
      check_both("dec_a");
    end
    check("dec_partial", 32'(lights_b != 10'h3FF), 1);
    set_in(16384, 16384);
    clk_step();
    set_in(0, 0);
    for (int i = 1; i <= 3; i++) begin
      clk_step();
      check_both("spike_m");
    end
    check("spike", 32'(lights_b), 32'h3FF);
    prev_n = $countones(lights_b);
    for (int i = 0; i < 60; i++) begin
      clk_step();
      check_both("dec_b");
      cur_n = $countones(lights_b);
      check("dec_step", 32'((prev_n - cur_n) == 0 || (prev_n - cur_n) == 1), 1);
      prev_n = cur_n;
    end
    check("dec_zero", 32'(lights_b), 0);

    // Random stereo stream with a reset pulse mid-run
    for (int i = 0; i < 600; i++) begin
      int sh;
      sh = $urandom_range(0, 15);
      if ($urandom_range(0, 31) == 0) left = 16'sh8000;
      else left = $signed(SW'($urandom)) >>> sh;
      right = $signed(SW'($urandom)) >>> $urandom_range(0, 15);
      if (i == 300) begin
        reset = 1'b0;
        clk_step();
        check("mid_rst_a", 32'(lights_a), 0);
        check("mid_rst_b", 32'(lights_b), 0);
        reset = 1'b1;
      end else begin
        clk_step();
        check_both("rand");
        check("therm_a", 32'(lights_a & NL'(lights_a + 1'b1)), 0);
        check("therm_b", 32'(lights_b & NL'(lights_b + 1'b1)), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
